xor_checksum_ctrl: RTL and testbench

XOR_CHECKSUM_CTRL -- requirements
Module: xor_checksum_ctrl

---
 rtl/xor_checksum_ctrl.sv | 115 +++++++++++
 tb/tb_xor_checksum_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xor_checksum_ctrl.sv
// XOR checksum job controller: accumulates a length-delimited stream of 32-bit words
// into a single XOR checksum, with abort, stall and back-to-back job support.

module xor32_unit (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] y_o
);

  assign y_o = a_i ^ b_i;

endmodule

module xor_checksum_ctrl #(
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  input  logic [31:0]      din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             busy,
  output logic             done,
  output logic [31:0]      result,
  output logic [LEN_W-1:0] words_left
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [LEN_W-1:0] One = LEN_W'(1);

  state_e           state_q;
  logic [31:0]      acc_q;
  logic [31:0]      acc_xor;
  logic [31:0]      result_q;
  logic [LEN_W-1:0] words_left_q;
  logic             din_ready_q;
  logic             busy_q;
  logic             done_q;

  xor32_unit u_xor (
    .a_i (acc_q),
    .b_i (din),
    .y_o (acc_xor)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      acc_q        <= '0;
      result_q     <= '0;
      words_left_q <= '0;
      din_ready_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            acc_q        <= '0;
            words_left_q <= len;
            busy_q       <= 1'b1;
            if (len == '0) begin
              // Empty job: checksum of nothing is zero, published immediately.
              state_q  <= StDone;
              result_q <= '0;
              done_q   <= 1'b1;
            end else begin
              state_q     <= StRun;
              din_ready_q <= 1'b1;
            end
          end
        end
        StRun: begin
          // Abort wins over a simultaneous handshake; that word is dropped.
          if (abort) begin
            state_q     <= StIdle;
            din_ready_q <= 1'b0;
            busy_q      <= 1'b0;
          end else if (din_valid && (words_left_q != '0)) begin
            acc_q        <= acc_xor;
            words_left_q <= words_left_q - One;
            if (words_left_q == One) begin
              state_q     <= StDone;
              result_q    <= acc_xor;
              din_ready_q <= 1'b0;
              done_q      <= 1'b1;
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q     <= StIdle;
          din_ready_q <= 1'b0;
          busy_q      <= 1'b0;
          done_q      <= 1'b0;
        end
      endcase
    end
  end

  assign din_ready  = din_ready_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign result     = result_q;
  assign words_left = words_left_q;

endmodule

// File: tb/tb_xor_checksum_ctrl.sv
// Self-checking bench for xor_checksum_ctrl: directed scenarios plus randomized jobs
// checked against a queue-based XOR fold reference.

module tb_xor_checksum_ctrl;

  localparam int unsigned LEN_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             abort;
  logic [31:0]      din;
  logic             din_valid;
  logic             din_ready;
  logic             busy;
  logic             done;
  logic [31:0]      result;
  logic [LEN_W-1:0] words_left;

  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  logic [31:0] model_result = '0;

  xor_checksum_ctrl #(.LEN_W(LEN_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .len        (len),
    .abort      (abort),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .words_left (words_left)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; len = '0; abort = 1'b0; din = '0; din_valid = 1'b0;
    repeat (2) tick;
    checks++;
    if ({din_ready, busy, done} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags: got ready/busy/done=%b required 000", {din_ready, busy, done});
    end
    checks++;
    if (result !== 32'h0 || words_left !== '0) begin
      errors++;
      $display("FAIL reset_data: got result=%h words_left=%0d required 0/0", result, words_left);
    end
    rst = 1'b0;
    tick;
    checks++;
    if (busy !== 1'b0 || din_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: got busy=%b ready=%b required 0/0", busy, din_ready);
    end
  endtask

  task automatic test_basic;
    logic [31:0] w [3];
    w[0] = 32'h0000FFFF; w[1] = 32'h00FF00FF; w[2] = 32'h0F0F0F0F;
    done_cnt = 0;
    start = 1'b1; len = LEN_W'(3); tick; start = 1'b0;
    checks++;
    if (din_ready !== 1'b1 || busy !== 1'b1 || words_left !== LEN_W'(3)) begin
      errors++;
      $display("FAIL basic_run_entry: got ready=%b busy=%b wl=%0d required 1/1/3",
               din_ready, busy, words_left);
    end
    for (int i = 0; i < 3; i++) begin
      din = w[i]; din_valid = 1'b1; tick;
      if (i < 2) begin
        checks++;
        if (done !== 1'b0 || words_left !== LEN_W'(2 - i)) begin
          errors++;
          $display("FAIL basic_progress%0d: got done=%b wl=%0d required 0/%0d",
                   i, done, words_left, 2 - i);
        end
      end
    end
    din_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || result !== 32'h0FF0F00F || words_left !== '0 ||
        din_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_done: got done=%b result=%h wl=%0d ready=%b busy=%b required 1/0ff0f00f/0/0/1",
               done, result, words_left, din_ready, busy);
    end
    model_result = 32'h0FF0F00F;
    tick;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || done_cnt != 1) begin
      errors++;
      $display("FAIL basic_after: got done=%b busy=%b pulses=%0d required 0/0/1", done, busy, done_cnt);
    end
  endtask

  task automatic test_stall;
    done_cnt = 0;
    start = 1'b1; len = LEN_W'(2); tick; start = 1'b0;
    din = 32'hA5A5A5A5; din_valid = 1'b1; tick;
    din_valid = 1'b0; din = 32'h11111111;
    repeat (3) begin
      tick;
      checks++;
      if (words_left !== LEN_W'(1) || din_ready !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold: got wl=%0d ready=%b done=%b required 1/1/0", words_left, din_ready, done);
      end
    end
    din = 32'hFFFFFFFF; din_valid = 1'b1; tick; din_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || result !== 32'h5A5A5A5A) begin
      errors++;
      $display("FAIL stall_result: got done=%b result=%h required 1/5a5a5a5a", done, result);
    end
    model_result = 32'h5A5A5A5A;
    repeat (2) tick;
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL stall_pulses: got %0d required 1", done_cnt);
    end
  endtask

  task automatic test_zero_len;
    done_cnt = 0;
    start = 1'b1; len = '0; tick; start = 1'b0;
    checks++;
    if (din_ready !== 1'b0 || done !== 1'b1 || busy !== 1'b1 || result !== 32'h0) begin
      errors++;
      $display("FAIL zero_len: got ready=%b done=%b busy=%b result=%h required 0/1/1/0",
               din_ready, done, busy, result);
    end
    model_result = 32'h0;
    tick;
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || din_ready !== 1'b0) begin
      errors++;
      $display("FAIL zero_len_after: got done=%b busy=%b ready=%b required 0/0/0", done, busy, din_ready);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] q [$];
    logic [31:0] exp;
    done_cnt = 0;
    start = 1'b1; len = LEN_W'(2); tick;
    len = LEN_W'(5);  // start stays high; a RUN-time reload would show up in words_left
    for (int i = 0; i < 2; i++) begin
      din = $urandom; din_valid = 1'b1; q.push_back(din); tick;
      if (i == 0) begin
        checks++;
        if (words_left !== LEN_W'(1)) begin
          errors++;
          $display("FAIL b2b_start_ignored: got wl=%0d required 1", words_left);
        end
      end
    end
    din_valid = 1'b0;
    exp = '0;
    foreach (q[k]) exp ^= q[k];
    checks++;
    if (done !== 1'b1 || result !== exp) begin
      errors++;
      $display("FAIL b2b_first_done: got done=%b result=%h required 1/%h", done, result, exp);
    end
    tick;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap: got busy=%b done=%b required 0/0", busy, done);
    end
    tick; start = 1'b0;
    checks++;
    if (busy !== 1'b1 || din_ready !== 1'b1 || words_left !== LEN_W'(5)) begin
      errors++;
      $display("FAIL b2b_second_start: got busy=%b ready=%b wl=%0d required 1/1/5", busy, din_ready, words_left);
    end
    q.delete();
    for (int i = 0; i < 5; i++) begin
      din = $urandom; din_valid = 1'b1; q.push_back(din); tick;
    end
    din_valid = 1'b0;
    exp = '0;
    foreach (q[k]) exp ^= q[k];
    checks++;
    if (done !== 1'b1 || result !== exp) begin
      errors++;
      $display("FAIL b2b_second_done: got done=%b result=%h required 1/%h", done, result, exp);
    end
    model_result = exp;
    tick;
    checks++;
    if (done_cnt != 2) begin
      errors++;
      $display("FAIL b2b_pulses: got %0d required 2", done_cnt);
    end
  endtask

  task automatic test_abort_restart;
    done_cnt = 0;
    start = 1'b1; len = LEN_W'(4); tick; start = 1'b0;
    din = $urandom; din_valid = 1'b1; tick;
    din = $urandom; abort = 1'b1; tick;
    abort = 1'b0; din_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || din_ready !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: got busy=%b ready=%b done=%b required 0/0/0", busy, din_ready, done);
    end
    checks++;
    if (result !== model_result || words_left !== LEN_W'(3)) begin
      errors++;
      $display("FAIL abort_hold: got result=%h wl=%0d required %h/3", result, words_left, model_result);
    end
    abort = 1'b1; tick; abort = 1'b0;  // ignored in IDLE
    start = 1'b1; len = LEN_W'(1); tick; start = 1'b0;
    din = 32'h12345678; din_valid = 1'b1; tick; din_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || result !== 32'h12345678) begin
      errors++;
      $display("FAIL abort_restart: got done=%b result=%h required 1/12345678", done, result);
    end
    model_result = 32'h12345678;
    tick;
    checks++;
    if (done_cnt != 1) begin
      errors++;
      $display("FAIL abort_pulses: got %0d required 1", done_cnt);
    end
  endtask

  task automatic test_reset_mid_job;
    done_cnt = 0;
    start = 1'b1; len = LEN_W'(7); tick; start = 1'b0;
    repeat (2) begin
      din = $urandom; din_valid = 1'b1; tick;
    end
    din_valid = 1'b0;
    checks++;
    if (words_left !== LEN_W'(5)) begin
      errors++;
      $display("FAIL rstmid_setup: got wl=%0d required 5", words_left);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({din_ready, busy, done} !== 3'b000 || result !== 32'h0 || words_left !== '0) begin
      errors++;
      $display("FAIL rstmid_async: got rdy/busy/done=%b result=%h wl=%0d required 000/0/0",
               {din_ready, busy, done}, result, words_left);
    end
    #2 rst = 1'b0;
    start = 1'b1; len = LEN_W'(1); tick; start = 1'b0;
    din = 32'hDEADBEEF; din_valid = 1'b1; tick; din_valid = 1'b0;
    checks++;
    if (done !== 1'b1 || result !== 32'hDEADBEEF || done_cnt != 0) begin
      errors++;
      $display("FAIL rstmid_newjob: got done=%b result=%h prior_pulses=%0d required 1/deadbeef/0",
               done, result, done_cnt);
    end
    model_result = 32'hDEADBEEF;
    tick;
  endtask

  task automatic test_random_jobs(input int njobs, input bit max_len);
    for (int j = 0; j < njobs; j++) begin
      logic [31:0] q [$];
      logic [31:0] exp;
      logic [31:0] w;
      int n;
      int acc_cnt;
      int budget;
      bit v;
      if (max_len) n = (1 << LEN_W) - 1;
      else if ($urandom_range(0, 7) == 0) n = 0;
      else n = $urandom_range(1, 20);
      done_cnt = 0;
      acc_cnt = 0;
      budget = 0;
      start = 1'b1; len = LEN_W'(n); tick; start = 1'b0; len = LEN_W'($urandom);
      while (acc_cnt < n && budget < 40 * n + 10) begin
        v = ($urandom_range(0, 3) != 0);
        w = $urandom;
        din = w; din_valid = v; tick; budget++;
        if (v) begin
          q.push_back(w);
          acc_cnt++;
        end
        if (acc_cnt < n) begin
          checks++;
          if (done !== 1'b0 || din_ready !== 1'b1 || words_left !== LEN_W'(n - acc_cnt)) begin
            errors++;
            $display("FAIL rand_job%0d_progress: got done=%b ready=%b wl=%0d required 0/1/%0d",
                     j, done, din_ready, words_left, n - acc_cnt);
          end
        end
      end
      din_valid = 1'b0;
      exp = '0;
      foreach (q[k]) exp ^= q[k];
      checks++;
      if (done !== 1'b1 || result !== exp) begin
        errors++;
        $display("FAIL rand_job%0d_done len=%0d: got done=%b result=%h required 1/%h",
                 j, n, done, result, exp);
      end
      model_result = exp;
      tick;
      checks++;
      if (busy !== 1'b0 || done_cnt != 1) begin
        errors++;
        $display("FAIL rand_job%0d_after: got busy=%b pulses=%0d required 0/1", j, busy, done_cnt);
      end
      repeat ($urandom_range(0, 2)) tick;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_zero_len();
    test_back_to_back();
    test_abort_restart();
    test_reset_mid_job();
    test_random_jobs(30, 1'b0);
    test_random_jobs(1, 1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
